// File: rtl/ysyx_25030093_lsu_pkg.sv
// ysyx_25030093_lsu_pkg
// Shared definitions for the AXI4-Lite load/store unit. It holds the memory-op
// encodings, the FSM state codes, the error codes, and small decode helpers
// used by both the top level and the alignment datapath.
// No ports. The optional misalignment check (macro LSU_MISALIGN_CHECK_EN) lives
// in the top level and does not change anything here.
package ysyx_25030093_lsu_pkg;

  // Memory-op encodings as driven on in_op.
  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;
  localparam logic [3:0] OP_LWU = 4'd8;
  localparam logic [3:0] OP_LD  = 4'd9;
  localparam logic [3:0] OP_SD  = 4'd10;

  // FSM state codes.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AW_W = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // Result error codes.
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_BUS      = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;

  // log2 of the access size in bytes (0=byte .. 3=doubleword).
  function automatic logic [1:0] access_lg(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB:  return 2'd0;
      OP_LH, OP_LHU, OP_SH:  return 2'd1;
      OP_LW, OP_SW, OP_LWU:  return 2'd2;
      OP_LD, OP_SD:          return 2'd3;
      default:               return 2'd0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
  endfunction

  // The 64-bit-only ops (lwu/ld/sd) are accepted only on a 64-bit datapath.
  function automatic logic op_legal(input logic [3:0] op, input logic wide);
    return (op <= OP_SW) || (wide && (op <= OP_SD));
  endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_align.sv
// ysyx_25030093_lsu_align
// Combinational alignment datapath for the LSU.
// Load side: shifts the bus word down by the byte offset, then sign- or
// zero-extends it according to the op.
// Store side: shifts right-aligned store data up onto its byte lanes and
// builds the matching write strobes.
// Ports:
//   ld_op, ld_off, ld_rdata -> ld_data           (load extract/extend)
//   st_op, st_off, st_wdata -> st_data, st_strb  (store lane steering)
import ysyx_25030093_lsu_pkg::*;

module ysyx_25030093_lsu_align #(
  parameter int DATA_W = 32
) (
  input  logic [3:0]                  ld_op,
  input  logic [$clog2(DATA_W/8)-1:0] ld_off,
  input  logic [DATA_W-1:0]           ld_rdata,
  output logic [DATA_W-1:0]           ld_data,
  input  logic [3:0]                  st_op,
  input  logic [$clog2(DATA_W/8)-1:0] st_off,
  input  logic [DATA_W-1:0]           st_wdata,
  output logic [DATA_W-1:0]           st_data,
  output logic [DATA_W/8-1:0]         st_strb
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] ld_shifted;
  logic [STRB_W-1:0] st_base;

  // A sized cast of a signed value sign-extends, so the same expression
  // works for both the 32- and the 64-bit datapath.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    case (ld_op)
      OP_LB:   ld_data = DATA_W'($signed(ld_shifted[7:0]));
      OP_LH:   ld_data = DATA_W'($signed(ld_shifted[15:0]));
      OP_LW:   ld_data = DATA_W'($signed(ld_shifted[31:0]));
      OP_LBU:  ld_data = DATA_W'(ld_shifted[7:0]);
      OP_LHU:  ld_data = DATA_W'(ld_shifted[15:0]);
      OP_LWU:  ld_data = DATA_W'(ld_shifted[31:0]);
      default: ld_data = ld_shifted;
    endcase
  end

  // Bits of st_wdata above the access size land on lanes whose strobe is
  // clear, so they need no masking.
  always_comb begin
    case (access_lg(st_op))
      2'd0:    st_base = STRB_W'(1);
      2'd1:    st_base = STRB_W'(3);
      2'd2:    st_base = STRB_W'(15);
      default: st_base = '1;
    endcase
    st_strb = st_base << st_off;
    st_data = st_wdata << {st_off, 3'b000};
  end

endmodule

// File: rtl/ysyx_25030093_lsu_axil.sv
// ysyx_25030093_lsu_axil
// Load/store unit with an AXI4-Lite-style master port. It accepts one memory
// op per in_valid/in_ready handshake and runs it on AR/R (loads) or AW/W/B
// (stores). It returns extended load data and an error code on out_*, and
// keeps only one transaction outstanding at a time.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready, in_op, in_addr, in_wdata       upstream request
//   out_valid/out_ready, out_rdata, out_err           downstream result
//   mem_addr, mem_ar*, mem_r*, mem_aw*, mem_w*, mem_b* AXI4-Lite master
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned accesses
// with out_err=10 instead of forcing natural alignment.
import ysyx_25030093_lsu_pkg::*;

module ysyx_25030093_lsu_axil #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_rdata,
  output logic [1:0]          out_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_arvalid,
  input  logic                mem_arready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [1:0]          mem_rresp,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  output logic                mem_awvalid,
  input  logic                mem_awready,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_wvalid,
  input  logic                mem_wready,
  input  logic [1:0]          mem_bresp,
  input  logic                mem_bvalid,
  output logic                mem_bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic [2:0]        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] out_rdata_q, out_rdata_d;
  logic [1:0]        out_err_q, out_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;

  logic [OFF_W-1:0]  lo_mask;
  logic [OFF_W-1:0]  in_off;
  logic              misalign;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_data;
  logic [STRB_W-1:0] st_strb;

  // The low address bits inside the access size form the alignment mask.
  // Clearing them gives the naturally aligned byte offset.
  assign lo_mask = OFF_W'((1 << access_lg(in_op)) - 1);
  assign in_off  = in_addr[OFF_W-1:0] & ~lo_mask;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = |(in_addr[OFF_W-1:0] & lo_mask);
`else
  assign misalign = 1'b0;
`endif

  // The load path uses the latched op and offset with the live bus data.
  // The store path steers the request's data at accept time, so the W
  // payload is a plain register.
  ysyx_25030093_lsu_align #(.DATA_W(DATA_W)) u_align (
    .ld_op    (op_q),
    .ld_off   (off_q),
    .ld_rdata (mem_rdata),
    .ld_data  (ld_data),
    .st_op    (in_op),
    .st_off   (in_off),
    .st_wdata (in_wdata),
    .st_data  (st_data),
    .st_strb  (st_strb)
  );

  // Every bus valid/ready decodes only registered state, so no input reaches
  // them combinationally.
  assign in_ready    = (state_q == ST_IDLE);
  assign mem_arvalid = (state_q == ST_AR);
  assign mem_rready  = (state_q == ST_R);
  assign mem_awvalid = (state_q == ST_AW_W) && !aw_done_q;
  assign mem_wvalid  = (state_q == ST_AW_W) && !w_done_q;
  assign mem_bready  = (state_q == ST_B);
  assign out_valid   = (state_q == ST_DONE);
  assign out_rdata   = out_rdata_q;
  assign out_err     = out_err_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = strb_q;

  // Illegal ops and (optionally) misaligned ops skip the bus and go straight
  // to DONE. AW and W finish independently, and B is entered only once both
  // handshakes have completed.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    out_rdata_d = out_rdata_q;
    out_err_d   = out_err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d        = in_op;
          off_d       = in_off;
          addr_d      = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          out_rdata_d = '0;
          out_err_d   = ERR_OK;
          if (!op_legal(in_op, DATA_W == 64)) begin
            state_d   = ST_DONE;
            out_err_d = ERR_BUS;
          end else if (misalign) begin
            state_d   = ST_DONE;
            out_err_d = ERR_MISALIGN;
          end else if (is_store(in_op)) begin
            state_d = ST_AW_W;
            wdata_d = st_data;
            strb_d  = st_strb;
          end else begin
            state_d = ST_AR;
          end
        end
      end
      ST_AR: begin
        if (mem_arready) state_d = ST_R;
      end
      ST_R: begin
        if (mem_rvalid) begin
          out_rdata_d = ld_data;
          out_err_d   = (mem_rresp != 2'b00) ? ERR_BUS : ERR_OK;
          state_d     = ST_DONE;
        end
      end
      ST_AW_W: begin
        aw_done_d = aw_done_q | mem_awready;
        w_done_d  = w_done_q | mem_wready;
        if (aw_done_d && w_done_d) state_d = ST_B;
      end
      ST_B: begin
        if (mem_bvalid) begin
          out_err_d = (mem_bresp != 2'b00) ? ERR_BUS : ERR_OK;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The asynchronous reset drops every valid/ready at once. Bus responses
  // that arrive later are ignored because the FSM is back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LB;
      off_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      out_rdata_q <= '0;
      out_err_q   <= ERR_OK;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      out_rdata_q <= out_rdata_d;
      out_err_q   <= out_err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_lsu_axil.sv
// tb_ysyx_25030093_lsu_axil
// Directed testbench for the AXI4-Lite LSU with a 32-bit datapath. The bus
// slave is modelled by hand-driven handshake signals, and every expected
// value is a hand-computed constant. Both builds are handled:
// LSU_MISALIGN_CHECK_EN selects the expected behaviour of the misaligned lw.
`timescale 1ns/1ps

module tb_ysyx_25030093_lsu_axil;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [1:0]  out_err;
  logic [31:0] mem_addr;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rvalid;
  logic        mem_rready;
  logic        mem_awvalid;
  logic        mem_awready;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [1:0]  mem_bresp;
  logic        mem_bvalid;
  logic        mem_bready;

  int checks = 0;
  int errors = 0;

  ysyx_25030093_lsu_axil #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_addr     (in_addr),
    .in_wdata    (in_wdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rdata   (out_rdata),
    .out_err     (out_err),
    .mem_addr    (mem_addr),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rvalid  (mem_rvalid),
    .mem_rready  (mem_rready),
    .mem_awvalid (mem_awvalid),
    .mem_awready (mem_awready),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_wvalid  (mem_wvalid),
    .mem_wready  (mem_wready),
    .mem_bresp   (mem_bresp),
    .mem_bvalid  (mem_bvalid),
    .mem_bready  (mem_bready)
  );

  always #5 clk = ~clk;

  // Advance one cycle: the rising edge does the work, and sampling/driving
  // happens on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one request for exactly one rising edge. in_ready is known to be
  // high, so the request is accepted on that edge. Returns in cycle 1.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata);
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    in_wdata = wdata;
    step();
    in_valid = 1'b0;
  endtask

  // Complete the DONE handshake and return to IDLE.
  task automatic drainResult();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_op       = 4'd0;
    in_addr     = '0;
    in_wdata    = '0;
    out_ready   = 1'b0;
    mem_arready = 1'b0;
    mem_rdata   = '0;
    mem_rresp   = 2'b00;
    mem_rvalid  = 1'b0;
    mem_awready = 1'b0;
    mem_wready  = 1'b0;
    mem_bresp   = 2'b00;
    mem_bvalid  = 1'b0;
    $display("[TB] start");

    // Reset values.
    step();
    checkOutput("rst_in_ready",  in_ready,    1);
    checkOutput("rst_out_valid", out_valid,   0);
    checkOutput("rst_arvalid",   mem_arvalid, 0);
    checkOutput("rst_rready",    mem_rready,  0);
    checkOutput("rst_awvalid",   mem_awvalid, 0);
    checkOutput("rst_wvalid",    mem_wvalid,  0);
    checkOutput("rst_bready",    mem_bready,  0);
    checkOutput("rst_out_rdata", out_rdata,   0);
    checkOutput("rst_out_err",   out_err,     0);
    checkOutput("rst_mem_addr",  mem_addr,    0);
    checkOutput("rst_wdata",     mem_wdata,   0);
    checkOutput("rst_wstrb",     mem_wstrb,   0);
    rst_n = 1'b1;
    step();

    // lb 0x103, zero-wait slave: arvalid cycle 1, rready cycle 2, out cycle 3.
    mem_arready = 1'b1;
    applyStimulus(4'd0, 32'h0000_0103, 32'h0);
    checkOutput("lb_c1_arvalid",  mem_arvalid, 1);
    checkOutput("lb_c1_in_ready", in_ready,    0);
    checkOutput("lb_c1_addr",     mem_addr,    32'h0000_0100);
    step();
    checkOutput("lb_c2_rready",  mem_rready,  1);
    checkOutput("lb_c2_arvalid", mem_arvalid, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF_1234;
    mem_rresp  = 2'b00;
    step();
    mem_rvalid = 1'b0;
    checkOutput("lb_c3_out_valid", out_valid, 1);
    checkOutput("lb_c3_rdata",     out_rdata, 32'hFFFF_FF80);
    checkOutput("lb_c3_err",       out_err,   2'b00);
    drainResult();
    checkOutput("lb_back_idle", in_ready, 1);

    // sh 0x202: AW accepted two cycles before W, each held until its ready.
    mem_arready = 1'b0;
    applyStimulus(4'd6, 32'h0000_0202, 32'h0000_ABCD);
    checkOutput("sh_c1_awvalid", mem_awvalid, 1);
    checkOutput("sh_c1_wvalid",  mem_wvalid,  1);
    checkOutput("sh_c1_addr",    mem_addr,    32'h0000_0200);
    checkOutput("sh_c1_wdata",   mem_wdata,   32'hABCD_0000);
    checkOutput("sh_c1_wstrb",   mem_wstrb,   4'b1100);
    mem_awready = 1'b1;
    step();
    mem_awready = 1'b0;
    checkOutput("sh_c2_awvalid", mem_awvalid, 0);
    checkOutput("sh_c2_wvalid",  mem_wvalid,  1);
    checkOutput("sh_c2_bready",  mem_bready,  0);
    step();
    checkOutput("sh_c3_wvalid", mem_wvalid, 1);
    checkOutput("sh_c3_wdata",  mem_wdata,  32'hABCD_0000);
    mem_wready = 1'b1;
    step();
    mem_wready = 1'b0;
    checkOutput("sh_c4_wvalid", mem_wvalid, 0);
    checkOutput("sh_c4_bready", mem_bready, 1);
    mem_bvalid = 1'b1;
    mem_bresp  = 2'b00;
    step();
    mem_bvalid = 1'b0;
    checkOutput("sh_out_valid", out_valid, 1);
    checkOutput("sh_out_rdata", out_rdata, 0);
    checkOutput("sh_out_err",   out_err,   2'b00);
    drainResult();

    // sb 0x203 with both AW and W ready at once; bus error on B.
    mem_awready = 1'b1;
    mem_wready  = 1'b1;
    applyStimulus(4'd5, 32'h0000_0203, 32'h1234_567F);
    checkOutput("sb_wdata", mem_wdata, 32'h7F00_0000);
    checkOutput("sb_wstrb", mem_wstrb, 4'b1000);
    step();
    mem_awready = 1'b0;
    mem_wready  = 1'b0;
    checkOutput("sb_bready",  mem_bready,  1);
    checkOutput("sb_awvalid", mem_awvalid, 0);
    mem_bvalid = 1'b1;
    mem_bresp  = 2'b10;
    step();
    mem_bvalid = 1'b0;
    mem_bresp  = 2'b00;
    checkOutput("sb_out_err", out_err, 2'b01);
    drainResult();

    // lw 0x300 with arready delayed three cycles and an error response.
    applyStimulus(4'd2, 32'h0000_0300, 32'h0);
    checkOutput("lwerr_c1_arvalid", mem_arvalid, 1);
    step();
    checkOutput("lwerr_c2_arvalid", mem_arvalid, 1);
    step();
    checkOutput("lwerr_c3_arvalid", mem_arvalid, 1);
    checkOutput("lwerr_c3_addr",    mem_addr,    32'h0000_0300);
    mem_arready = 1'b1;
    step();
    mem_arready = 1'b0;
    checkOutput("lwerr_rready", mem_rready, 1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    mem_rresp  = 2'b10;
    step();
    mem_rvalid = 1'b0;
    mem_rresp  = 2'b00;
    checkOutput("lwerr_out_valid", out_valid, 1);
    checkOutput("lwerr_out_err",   out_err,   2'b01);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("lwerr_hold_valid", out_valid, 1);
      checkOutput("lwerr_hold_err",   out_err,   2'b01);
    end
    drainResult();
    checkOutput("lwerr_idle", in_ready, 1);

    // Unsupported op (lwu on a 32-bit datapath): bus error, no traffic.
    applyStimulus(4'd8, 32'h0000_0400, 32'h0);
    checkOutput("illegal_out_valid", out_valid,   1);
    checkOutput("illegal_out_err",   out_err,     2'b01);
    checkOutput("illegal_arvalid",   mem_arvalid, 0);
    checkOutput("illegal_awvalid",   mem_awvalid, 0);
    drainResult();

    // Misaligned lw 0x101.
    mem_arready = 1'b1;
    applyStimulus(4'd2, 32'h0000_0101, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    checkOutput("mis_out_valid", out_valid,   1);
    checkOutput("mis_out_err",   out_err,     2'b10);
    checkOutput("mis_arvalid",   mem_arvalid, 0);
    drainResult();
`else
    checkOutput("mis_arvalid", mem_arvalid, 1);
    checkOutput("mis_addr",    mem_addr,    32'h0000_0100);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    checkOutput("mis_rdata", out_rdata, 32'hDEAD_BEEF);
    checkOutput("mis_err",   out_err,   2'b00);
    drainResult();
`endif

    // Reset asserted while waiting in R.
    applyStimulus(4'd2, 32'h0000_0500, 32'h0);
    step();
    checkOutput("rstmid_rready_before", mem_rready, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_rready",   mem_rready, 0);
    checkOutput("rstmid_in_ready", in_ready,   1);
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_5555;
    step();
    mem_rvalid = 1'b0;
    checkOutput("rstmid_late_out_valid", out_valid, 0);
    checkOutput("rstmid_late_in_ready",  in_ready,  1);

    // lbu 0x105 after the reset completes normally.
    applyStimulus(4'd3, 32'h0000_0105, 32'h0);
    checkOutput("lbu_arvalid", mem_arvalid, 1);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_9A00;
    step();
    mem_rvalid = 1'b0;
    checkOutput("lbu_out_valid", out_valid, 1);
    checkOutput("lbu_rdata",     out_rdata, 32'h0000_009A);
    checkOutput("lbu_err",       out_err,   2'b00);
    drainResult();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
